// File: rtl/fadd_seq_ctrl_if.sv
// Request/response and slice-facing signal bundle for fadd_seq_ctrl.
// "slave" is the sequencer's view; "master" is the issue-logic/slice side.
interface fadd_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_sub;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_ovf;
    logic [3:0]       fa_a;
    logic [3:0]       fa_b;
    logic             fa_cin;
    logic [3:0]       fa_sum;
    logic             fa_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready, fa_sum, fa_cout,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, fa_a, fa_b, fa_cin
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready, fa_sum, fa_cout,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/fadd_seq_ctrl.sv
// WIDTH-bit add/subtract sequencer driving one shared 4-bit registered fadd slice, LS nibble first.
// Optional RUN-cycle counter on busy_cycles is built only when FADD_SEQ_PERF_EN is defined.
module fadd_seq_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    fadd_seq_ctrl_if.slave      bus,
    output logic [31:0]         busy_cycles
);
    localparam int NSLICE = WIDTH / 4;
    localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int WW     = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    localparam logic [SW-1:0] SLICE_LAST = SW'(NSLICE - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(ADD_LAT);

    // FINISH is a single internal cycle that registers the response flags.
    typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             carry_reg, carry_next;
    logic [SW-1:0]    slice_reg, slice_next;
    logic [WW-1:0]    wait_reg, wait_next;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] rsp_sum_reg, rsp_sum_next;
    logic             rsp_cout_reg, rsp_cout_next;
    logic             rsp_ovf_reg, rsp_ovf_next;
    logic             slice_done;

    logic [3:0]       a_nib [NSLICE];
    logic [3:0]       b_nib [NSLICE];

    assign slice_done = (state_reg == RUN) && (wait_reg == WAIT_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*4 +: 4];
            assign b_nib[gi] = b_reg[gi*4 +: 4];

            always_ff @(posedge clk) begin
                if (rst) begin
                    result_reg[gi*4 +: 4] <= 4'd0;
                end else if (slice_done && (slice_reg == SW'(gi))) begin
                    result_reg[gi*4 +: 4] <= bus.fa_sum;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            carry_reg    <= 1'b0;
            slice_reg    <= '0;
            wait_reg     <= '0;
            rsp_sum_reg  <= '0;
            rsp_cout_reg <= 1'b0;
            rsp_ovf_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            carry_reg    <= carry_next;
            slice_reg    <= slice_next;
            wait_reg     <= wait_next;
            rsp_sum_reg  <= rsp_sum_next;
            rsp_cout_reg <= rsp_cout_next;
            rsp_ovf_reg  <= rsp_ovf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        carry_next    = carry_reg;
        slice_next    = slice_reg;
        wait_next     = wait_reg;
        rsp_sum_next  = rsp_sum_reg;
        rsp_cout_next = rsp_cout_reg;
        rsp_ovf_next  = rsp_ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    a_next     = bus.req_a;
                    b_next     = bus.req_sub ? ~bus.req_b : bus.req_b;
                    carry_next = bus.req_sub;
                    slice_next = '0;
                    wait_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (wait_reg == WAIT_MAX) begin
                    wait_next  = '0;
                    carry_next = bus.fa_cout;
                    if (slice_reg == SLICE_LAST) begin
                        state_next = FINISH;
                    end else begin
                        slice_next = slice_reg + SW'(1);
                    end
                end else begin
                    wait_next = wait_reg + WW'(1);
                end
            end
            FINISH: begin
                rsp_sum_next  = result_reg;
                rsp_cout_next = carry_reg;
                rsp_ovf_next  = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (result_reg[WIDTH-1] != a_reg[WIDTH-1]);
                state_next    = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready = (state_reg == IDLE) && !rst;
    assign bus.rsp_valid = (state_reg == DONE);
    assign bus.rsp_sum   = rsp_sum_reg;
    assign bus.rsp_cout  = rsp_cout_reg;
    assign bus.rsp_ovf   = rsp_ovf_reg;
    assign bus.fa_a      = (state_reg == RUN) ? a_nib[slice_reg] : 4'd0;
    assign bus.fa_b      = (state_reg == RUN) ? b_nib[slice_reg] : 4'd0;
    assign bus.fa_cin    = (state_reg == RUN) ? carry_reg : 1'b0;

`ifdef FADD_SEQ_PERF_EN
    logic [31:0] busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 32'd0;
        end else if ((state_reg == RUN) && (busy_reg != 32'hFFFF_FFFF)) begin
            busy_reg <= busy_reg + 32'd1;
        end
    end

    assign busy_cycles = busy_reg;
`else
    assign busy_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_fadd_seq_ctrl.sv
// Directed bench for fadd_seq_ctrl with a behavioural 3-stage registered fadd slice model.
module tb_fadd_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] busy;
    int          errors = 0;
    int          checks = 0;

    logic [3:0]  log_a   [200];
    logic [3:0]  log_b   [200];
    logic        log_cin [200];

    logic [4:0]  s1, s2, s3;

    fadd_seq_ctrl_if #(.WIDTH(16)) bus ();

    fadd_seq_ctrl #(.WIDTH(16), .ADD_LAT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy_cycles (busy)
    );

    always #5 clk = ~clk;

    // Slice model: sum/cout valid after three edges of stable inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 5'd0;
            s2 <= 5'd0;
            s3 <= 5'd0;
        end else begin
            s1 <= {1'b0, bus.fa_a} + {1'b0, bus.fa_b} + {4'd0, bus.fa_cin};
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign bus.fa_sum  = s3[3:0];
    assign bus.fa_cout = s3[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int i = 0;
        while (!bus.req_ready && i < 50) begin
            step();
            i++;
        end
        chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_sub   = sub;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 199) begin
            log_a[n]   = bus.fa_a;
            log_b[n]   = bus.fa_b;
            log_cin[n] = bus.fa_cin;
            step();
            n++;
        end
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] es, input logic ec, input logic eo);
        int n;
        start_req(a, b, sub);
        wait_rsp(n);
        chk({tag, "_latency"}, n, 32'd17);
        chk({tag, "_sum"}, {16'd0, bus.rsp_sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, bus.rsp_cout}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, bus.rsp_ovf}, {31'd0, eo});
        $display("txn %s a=%h b=%h sub=%0d sum=%h cout=%0d ovf=%0d latency=%0d",
                 tag, a, b, sub, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf, n);
        take_rsp();
    endtask

    initial begin
        int n;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] held;
        bus.req_valid = 1'b0;
        bus.req_a     = 16'd0;
        bus.req_b     = 16'd0;
        bus.req_sub   = 1'b0;
        bus.rsp_ready = 1'b0;

        step();
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_sum", {16'd0, bus.rsp_sum}, 32'd0);
        chk("rst_rsp_cout", {31'd0, bus.rsp_cout}, 32'd0);
        chk("rst_rsp_ovf", {31'd0, bus.rsp_ovf}, 32'd0);
        chk("rst_fa", {23'd0, bus.fa_a, bus.fa_b, bus.fa_cin}, 32'd0);
        chk("rst_busy", busy, 32'd0);

        // 1: basic add with per-cycle slice input checks
        do_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        ea = 16'h1234;
        eb = 16'h4321;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("fa_a[%0d]", k), {28'd0, log_a[k]}, {28'd0, 4'((ea >> (4 * (k / 4))) & 16'hF)});
            chk($sformatf("fa_b[%0d]", k), {28'd0, log_b[k]}, {28'd0, 4'((eb >> (4 * (k / 4))) & 16'hF)});
            chk($sformatf("fa_cin[%0d]", k), {31'd0, log_cin[k]}, 32'd0);
        end

        // 2/3: carry, overflow and subtract boundaries
        do_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        chk("sub_cin0", {31'd0, log_cin[0]}, 32'd1);
        chk("sub_fab0", {28'd0, log_b[0]}, 32'h8);
        do_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // 4: backpressure in DONE with a competing request
        start_req(16'h0102, 16'h0304, 1'b0);
        wait_rsp(n);
        chk("bp_latency", n, 32'd17);
        held = bus.rsp_sum;
        chk("bp_sum", {16'd0, held}, 32'h0406);
        bus.req_valid = 1'b1;
        bus.req_a     = 16'h0A0B;
        bus.req_b     = 16'h0101;
        bus.req_sub   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_valid[%0d]", c), {31'd0, bus.rsp_valid}, 32'd1);
            chk($sformatf("bp_hold[%0d]", c), {16'd0, bus.rsp_sum}, 32'h0406);
            chk($sformatf("bp_req_ready[%0d]", c), {31'd0, bus.req_ready}, 32'd0);
        end
        $display("txn bp a=0102 b=0304 sum=%h held 5 cycles", bus.rsp_sum);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("bp_post_hs_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("bp_post_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        bus.req_valid = 1'b0;
        chk("bp_accepted", {31'd0, bus.req_ready}, 32'd0);
        wait_rsp(n);
        chk("bp2_latency", n, 32'd17);
        chk("bp2_sum", {16'd0, bus.rsp_sum}, 32'h0B0C);
        $display("txn bp2 a=0a0b b=0101 sum=%h latency=%0d", bus.rsp_sum, n);
        take_rsp();

        // 5: reset during slice 2
        start_req(16'h2222, 16'h3333, 1'b0);
        for (int c = 0; c < 9; c++) step();
        chk("mid_fa_a_slice2", {28'd0, bus.fa_a}, 32'h2);
        rst = 1'b1;
        step();
        chk("mrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("mrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mrst_rsp_sum", {16'd0, bus.rsp_sum}, 32'd0);
        chk("mrst_flags", {30'd0, bus.rsp_cout, bus.rsp_ovf}, 32'd0);
        chk("mrst_fa", {23'd0, bus.fa_a, bus.fa_b, bus.fa_cin}, 32'd0);
        chk("mrst_busy", busy, 32'd0);
        rst = 1'b0;
        #1;
        chk("mrst_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.rsp_valid) n++;
        end
        chk("mrst_no_rsp", n, 32'd0);
        $display("txn reset mid-run, no response");

        // 5/6: recovery then a second back-to-back add for the busy counter
        do_op("add_0001_0001", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        do_op("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
`ifdef FADD_SEQ_PERF_EN
        chk("busy_cycles", busy, 32'd32);
`else
        chk("busy_cycles", busy, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
